dump_readout_arbiter: RTL and testbench

Serialises correlator dump results from up to NUM_CH tracking channels onto one 16-bit valid/ready stream toward the bus interface. It latches each channel's `dump` pulse as a pending request and grants channels round-robin. For each grant it steps the external accumulator read mux through the six words I_E, Q_E, I_P, Q_P, I_L, Q_L and emits them in that order. It also flags channels whose new dump arrived before the previous one was fully read.

---
 rtl/dump_readout_arbiter_if.sv | 29 ++
 rtl/dump_readout_arbiter.sv | 136 +++++++++++++
 tb/tb_dump_readout_arbiter.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dump_readout_arbiter_if.sv
// Channel-side dump requests, accumulator read mux and 16-bit valid/ready readout stream.
// master modport belongs to the arbiter; slave modport belongs to the surrounding logic.
interface dump_readout_arbiter_if #(
   parameter int NUM_CH = 12,
   parameter int CH_W   = 4
);
   logic [NUM_CH-1:0] dump;
   logic [CH_W-1:0]   sel_ch;
   logic [2:0]        sel_word;
   logic [15:0]       acc_word;
   logic [15:0]       out_data;
   logic [CH_W-1:0]   out_ch;
   logic              out_last;
   logic              out_valid;
   logic              out_ready;
   logic [NUM_CH-1:0] pending;
   logic [NUM_CH-1:0] overrun;
   logic [NUM_CH-1:0] overrun_clr;

   modport master (
      input  dump, acc_word, out_ready, overrun_clr,
      output sel_ch, sel_word, out_data, out_ch, out_last, out_valid, pending, overrun
   );

   modport slave (
      output dump, acc_word, out_ready, overrun_clr,
      input  sel_ch, sel_word, out_data, out_ch, out_last, out_valid, pending, overrun
   );
endinterface

// File: rtl/dump_readout_arbiter.sv
// Round-robin readout of per-channel correlator dumps as 6-word records (2 cycles/word, stalls on out_ready).
// Defining DUMP_HEADER_EN prefixes each record with a header word carrying channel and overrun flag.
module dump_readout_arbiter #(
   parameter int NUM_CH = 12,
   parameter int CH_W   = 4
) (
   input logic                    clk,
   input logic                    rst,
   dump_readout_arbiter_if.master bus
);
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      SEND  = 2'd2
`ifdef DUMP_HEADER_EN
      , HDR = 2'd3
`endif
   } state_t;

   state_t            state_q;
   logic [CH_W-1:0]   sel_ch_q;
   logic [2:0]        sel_word_q;
   logic [CH_W-1:0]   last_grant_q;
   logic [15:0]       out_data_q;
   logic [CH_W-1:0]   out_ch_q;
   logic              out_last_q;
   logic              out_valid_q;
   logic [NUM_CH-1:0] pending_q;
   logic [NUM_CH-1:0] pending_d;
   logic [NUM_CH-1:0] overrun_q;
   logic [NUM_CH-1:0] overrun_d;

   logic              gnt_found;
   logic [CH_W-1:0]   gnt_idx;
   logic [NUM_CH-1:0] gnt_mask;
   logic [NUM_CH-1:0] active_mask;

   // Search starts one past the last grant so every pending channel is served within NUM_CH grants.
   always_comb begin : rr_search
      int              cand;
      logic [CH_W-1:0] cand_idx;
      cand      = 0;
      cand_idx  = '0;
      gnt_found = 1'b0;
      gnt_idx   = '0;
      for (int i = 1; i <= NUM_CH; i++) begin
         cand     = (int'(last_grant_q) + i) % NUM_CH;
         cand_idx = CH_W'(cand);
         if (!gnt_found && pending_q[cand_idx]) begin
            gnt_found = 1'b1;
            gnt_idx   = cand_idx;
         end
      end
   end

   always_comb begin
      gnt_mask    = (state_q == IDLE && gnt_found) ? (NUM_CH'(1) << gnt_idx) : '0;
      active_mask = (state_q != IDLE) ? (NUM_CH'(1) << sel_ch_q) : '0;
      pending_d   = (pending_q | bus.dump) & ~gnt_mask;
      overrun_d   = (overrun_q & ~bus.overrun_clr) | (bus.dump & (pending_q | active_mask));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         sel_ch_q     <= '0;
         sel_word_q   <= 3'd0;
         last_grant_q <= CH_W'(NUM_CH - 1);
         out_data_q   <= 16'h0000;
         out_ch_q     <= '0;
         out_last_q   <= 1'b0;
         out_valid_q  <= 1'b0;
         pending_q    <= '0;
         overrun_q    <= '0;
      end else begin
         pending_q <= pending_d;
         overrun_q <= overrun_d;
         case (state_q)
            IDLE: begin
               if (gnt_found) begin
                  sel_ch_q     <= gnt_idx;
                  sel_word_q   <= 3'd0;
                  last_grant_q <= gnt_idx;
`ifdef DUMP_HEADER_EN
                  out_data_q   <= {8'hA5, 3'b000, overrun_d[gnt_idx], 4'(gnt_idx)};
                  out_ch_q     <= gnt_idx;
                  out_last_q   <= 1'b0;
                  out_valid_q  <= 1'b1;
                  state_q      <= HDR;
`else
                  state_q      <= FETCH;
`endif
               end
            end
            // acc_word has had the whole FETCH cycle to settle after the select change.
            FETCH: begin
               out_data_q  <= bus.acc_word;
               out_ch_q    <= sel_ch_q;
               out_last_q  <= (sel_word_q == 3'd5);
               out_valid_q <= 1'b1;
               state_q     <= SEND;
            end
            SEND: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  if (sel_word_q == 3'd5) begin
                     state_q <= IDLE;
                  end else begin
                     sel_word_q <= sel_word_q + 3'd1;
                     state_q    <= FETCH;
                  end
               end
            end
`ifdef DUMP_HEADER_EN
            HDR: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  sel_word_q  <= 3'd0;
                  state_q     <= FETCH;
               end
            end
`endif
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.sel_ch    = sel_ch_q;
   assign bus.sel_word  = sel_word_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_ch    = out_ch_q;
   assign bus.out_last  = out_last_q;
   assign bus.out_valid = out_valid_q;
   assign bus.pending   = pending_q;
   assign bus.overrun   = overrun_q;
endmodule

// File: tb/tb_dump_readout_arbiter.sv
// Directed bench for dump_readout_arbiter: round-robin order, stalls, overrun, reset abort, optional header.
module tb_dump_readout_arbiter;
   localparam int NUM_CH = 12;
   localparam int CH_W   = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] acc_base;
   int          n_assert = 0;
   int          n_fail   = 0;

   dump_readout_arbiter_if #(.NUM_CH(NUM_CH), .CH_W(CH_W)) bus ();

   dump_readout_arbiter #(.NUM_CH(NUM_CH), .CH_W(CH_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Accumulator mux model: word value = base + word index.
   assign bus.acc_word = acc_base + 16'(bus.sel_word);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(input string tag);
      int n;
      n = 0;
      while (bus.out_valid !== 1'b1 && n < 64) begin
         step();
         n++;
      end
      chk({tag, "_valid_timeout"}, 32'(bus.out_valid), 32'd1);
   endtask

   // Expects out_ready=1: checks the presented word, then lets it handshake.
   task automatic get_word(input string tag, input logic [15:0] data, input logic [3:0] ch, input logic last);
      wait_valid(tag);
      chk(tag, {11'd0, bus.out_ch, bus.out_last, bus.out_data}, {11'd0, ch, last, data});
      step();
   endtask

   task automatic get_words(input string tag, input logic [3:0] ch, input logic [15:0] base,
                            input int from_w, input int to_w);
      for (int w = from_w; w <= to_w; w++)
         get_word($sformatf("%s_w%0d", tag, w), base + 16'(w), ch, (w == 5));
   endtask

`ifdef DUMP_HEADER_EN
   task automatic get_hdr(input string tag, input logic [3:0] ch, input logic ovr);
      get_word({tag, "_hdr"}, {8'hA5, 3'b000, ovr, ch}, ch, 1'b0);
   endtask
`endif

   task automatic get_record(input string tag, input logic [3:0] ch, input logic [15:0] base, input logic ovr);
`ifdef DUMP_HEADER_EN
      get_hdr(tag, ch, ovr);
`else
      chk({tag, "_ovr"}, 32'(bus.overrun[ch]), 32'(ovr));
`endif
      get_words(tag, ch, base, 0, 5);
   endtask

   task automatic count_idle(input string tag, input int cycles);
      int seen;
      seen = 0;
      for (int k = 0; k < cycles; k++) begin
         step();
         if (bus.out_valid === 1'b1) seen++;
      end
      chk(tag, 32'(seen), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst             = 1'b1;
      bus.dump        = '0;
      bus.out_ready   = 1'b1;
      bus.overrun_clr = '0;
      acc_base        = 16'h0100;
      step();
      step();
      chk("rst_ctl", 32'({bus.sel_ch, bus.sel_word, bus.out_ch, bus.out_last, bus.out_valid}), 32'd0);
      chk("rst_data", 32'(bus.out_data), 32'd0);
      chk("rst_pend", 32'(bus.pending), 32'd0);
      chk("rst_ovr", 32'(bus.overrun), 32'd0);
      rst = 1'b0;
      step();

      // Single dump on ch3: latency and word order.
      bus.out_ready = 1'b0;
      bus.dump = 12'h008;
      step();
      bus.dump = '0;
      chk("t1_pend", 32'(bus.pending), 32'h008);
      chk("t1_v1", 32'(bus.out_valid), 32'd0);
      step();
      chk("t1_pend_gnt", 32'(bus.pending), 32'd0);
`ifdef DUMP_HEADER_EN
      chk("t1_v2", 32'(bus.out_valid), 32'd1);
`else
      chk("t1_v2", 32'(bus.out_valid), 32'd0);
`endif
      step();
      chk("t1_v3", 32'(bus.out_valid), 32'd1);
      chk("t1_selch", 32'(bus.sel_ch), 32'd3);
      bus.out_ready = 1'b1;
      get_record("t1", 4'd3, 16'h0100, 1'b0);

      // Fresh round-robin pointer: simultaneous dumps on 0, 5, 11, then ch2 during ch11.
      rst = 1'b1;
      #1;
      rst = 1'b0;
      step();
      acc_base = 16'h0200;
      bus.dump = 12'h821;
      step();
      bus.dump = '0;
      chk("t2_pend", 32'(bus.pending), 32'h821);
      get_record("t2_c0", 4'd0, 16'h0200, 1'b0);
      get_record("t2_c5", 4'd5, 16'h0200, 1'b0);
      bus.dump = 12'h004;
      step();
      bus.dump = '0;
      get_record("t2_c11", 4'd11, 16'h0200, 1'b0);
      get_record("t2_c2", 4'd2, 16'h0200, 1'b0);
      chk("t2_ovr", 32'(bus.overrun), 32'd0);
      chk("t2_pend_end", 32'(bus.pending), 32'd0);

      // Backpressure for 10 cycles on word 2; acc_word wiggles meanwhile.
      acc_base = 16'h0300;
      bus.dump = 12'h002;
      step();
      bus.dump = '0;
`ifdef DUMP_HEADER_EN
      get_hdr("t3", 4'd1, 1'b0);
`endif
      get_words("t3", 4'd1, 16'h0300, 0, 1);
      wait_valid("t3_w2");
      bus.out_ready = 1'b0;
      acc_base = 16'hBEEF;
      for (int k = 0; k < 10; k++) begin
         step();
         chk($sformatf("t3_hold%0d", k), {10'd0, bus.out_valid, bus.out_ch, bus.out_last, bus.out_data},
             {10'd0, 1'b1, 4'd1, 1'b0, 16'h0302});
      end
      acc_base = 16'h0300;
      bus.out_ready = 1'b1;
      get_words("t3", 4'd1, 16'h0300, 2, 5);
      count_idle("t3_no_dup", 8);

      // Second dump on ch4 while still pending: overrun, single record.
      acc_base = 16'h0400;
      bus.dump = 12'h010;
      step();
      step();
      bus.dump = '0;
      chk("t4_ovr", 32'(bus.overrun), 32'h010);
      chk("t4_pend", 32'(bus.pending), 32'd0);
      get_record("t4a", 4'd4, 16'h0400, 1'b1);
      count_idle("t4_single", 20);
      bus.overrun_clr = 12'h010;
      step();
      bus.overrun_clr = '0;
      chk("t4_clr", 32'(bus.overrun), 32'd0);
      bus.dump = 12'h010;
      step();
      bus.overrun_clr = 12'h010;
      step();
      bus.dump = '0;
      bus.overrun_clr = '0;
      chk("t4_set_wins", 32'(bus.overrun), 32'h010);
      get_record("t4b", 4'd4, 16'h0400, 1'b1);
      bus.overrun_clr = 12'h010;
      step();
      bus.overrun_clr = '0;
      chk("t4_clr2", 32'(bus.overrun), 32'd0);

      // Dump on ch7 while its own word sits in SEND: overrun plus re-read.
      acc_base = 16'h0700;
      bus.dump = 12'h080;
      step();
      bus.dump = '0;
`ifdef DUMP_HEADER_EN
      get_hdr("t5", 4'd7, 1'b0);
`endif
      bus.out_ready = 1'b0;
      wait_valid("t5_w0");
      bus.dump = 12'h080;
      step();
      bus.dump = '0;
      chk("t5_ovr", 32'(bus.overrun), 32'h080);
      chk("t5_pend", 32'(bus.pending), 32'h080);
      bus.out_ready = 1'b1;
      get_words("t5a", 4'd7, 16'h0700, 0, 5);
      get_record("t5b", 4'd7, 16'h0700, 1'b1);
      chk("t5_pend_end", 32'(bus.pending), 32'd0);

      // Reset in the middle of a record with another channel pending.
      acc_base = 16'h0600;
      bus.dump = 12'h040;
      step();
      bus.dump = '0;
`ifdef DUMP_HEADER_EN
      get_hdr("t6", 4'd6, 1'b0);
`endif
      get_words("t6", 4'd6, 16'h0600, 0, 1);
      bus.dump = 12'h200;
      step();
      bus.dump = '0;
      chk("t6_pre_pend", 32'(bus.pending), 32'h200);
      chk("t6_pre_valid", 32'(bus.out_valid), 32'd1);
      rst = 1'b1;
      #1;
      chk("t6_async_valid", 32'(bus.out_valid), 32'd0);
      step();
      rst = 1'b0;
      chk("t6_ctl", 32'({bus.sel_ch, bus.sel_word, bus.out_ch, bus.out_last, bus.out_valid}), 32'd0);
      chk("t6_data", 32'(bus.out_data), 32'd0);
      chk("t6_pend", 32'(bus.pending), 32'd0);
      chk("t6_ovr", 32'(bus.overrun), 32'd0);
      count_idle("t6_no_resume", 30);

      // Overrun on ch9 from a double dump; header (if built) reports it.
      acc_base = 16'h0900;
      bus.dump = 12'h200;
      step();
      step();
      bus.dump = '0;
      chk("t7_ovr", 32'(bus.overrun), 32'h200);
      get_record("t7", 4'd9, 16'h0900, 1'b1);
      count_idle("t7_end", 10);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
